// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and default widths for the IFU/LSU memory-port arbiter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t (arbiter FSM states), owner_t (which requester holds the port),
//           default ADDR/DATA widths and timeout budget.
package mem_arb_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Purpose : chooses which requester gets the memory port when the arbiter is idle.
// Latency : combinational.
// Backpressure: none; the caller only uses the result while idle.
// Ports   : ifu_valid_i / lsu_valid_i  -- pending requests
//           last_grant_i               -- previous winner (only with MEM_ARB_RR_EN)
//           winner_o / grant_en_o      -- selected requester, and whether anyone asked
// Option  : MEM_ARB_RR_EN selects round-robin on ties; otherwise LSU beats IFU.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic   ifu_valid_i,
    input  logic   lsu_valid_i,
`ifdef MEM_ARB_RR_EN
    input  owner_t last_grant_i,
`endif
    output owner_t winner_o,
    output logic   grant_en_o
);

    always_comb begin
        winner_o   = OWN_IFU;
        grant_en_o = ifu_valid_i | lsu_valid_i;
        if (lsu_valid_i && !ifu_valid_i) begin
            winner_o = OWN_LSU;
        end else if (lsu_valid_i && ifu_valid_i) begin
`ifdef MEM_ARB_RR_EN
            // On a tie, whoever did not win last time goes first.
            winner_o = (last_grant_i == OWN_LSU) ? OWN_IFU : OWN_LSU;
`else
            winner_o = OWN_LSU;
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : shares one memory port between IFU (reads) and LSU (reads/writes), one transaction at a time.
// Latency : 3 cycles from request handshake to response valid with a zero-wait memory; 1 idle cycle between transactions.
// Backpressure: req_ready only in IDLE; owner's resp_valid is held until resp_ready; mem_resp_ready drops while a response is held.
// Ports   : ifu_req_* / ifu_resp_*  -- instruction fetch request/response (read only)
//           lsu_req_* / lsu_resp_*  -- load/store request/response
//           mem_req_* / mem_resp_*  -- single downstream memory port, request fields registered
// Option  : MEM_ARB_RR_EN -- round-robin tie-breaking (last_grant resets to LSU); default is fixed LSU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_resp_data,
    output logic                ifu_resp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_resp_data,
    output logic                lsu_resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_resp_data
);

    // Counter only has to reach TIMEOUT_CYCLES; keep at least one bit when disabled.
    localparam int             TO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic           TO_EN    = (TIMEOUT_CYCLES != 0);

    state_t              state_q;
    owner_t              owner_q;
    logic                mem_req_valid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic                resp_err_q;
    logic                ifu_resp_valid_q;
    logic                lsu_resp_valid_q;
    logic [TO_W-1:0]     cnt_q;
    logic [TO_W-1:0]     cnt_d;
    logic                timeout_hit;
    logic                owner_resp_ready;
    owner_t              winner;
    logic                grant_en;
    logic                accept;

`ifdef MEM_ARB_RR_EN
    owner_t              last_grant_q;
`endif

    mem_arb_picker u_picker (
        .ifu_valid_i  (ifu_req_valid),
        .lsu_valid_i  (lsu_req_valid),
`ifdef MEM_ARB_RR_EN
        .last_grant_i (last_grant_q),
`endif
        .winner_o     (winner),
        .grant_en_o   (grant_en)
    );

    assign accept        = (state_q == IDLE) && grant_en;
    assign ifu_req_ready = accept && (winner == OWN_IFU);
    assign lsu_req_ready = accept && (winner == OWN_LSU);

    // Saturate at the limit: if a handshake beats the timeout in REQ, the
    // count must still match the limit in WAIT rather than wrap past it.
    assign cnt_d       = (cnt_q == TO_LIMIT) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = TO_EN && (cnt_q == TO_LIMIT);

    assign owner_resp_ready = (owner_q == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            owner_q          <= OWN_IFU;
            mem_req_valid_q  <= 1'b0;
            addr_q           <= '0;
            wen_q            <= 1'b0;
            wdata_q          <= '0;
            wmask_q          <= '0;
            resp_data_q      <= '0;
            resp_err_q       <= 1'b0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            cnt_q            <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q     <= OWN_LSU;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // A stray mem_resp_valid here is a late answer to a timed-out request; ignore it.
                    if (grant_en) begin
                        state_q         <= REQ;
                        owner_q         <= winner;
                        mem_req_valid_q <= 1'b1;
                        cnt_q           <= '0;
`ifdef MEM_ARB_RR_EN
                        last_grant_q    <= winner;
`endif
                        if (winner == OWN_LSU) begin
                            addr_q  <= lsu_req_addr;
                            wen_q   <= lsu_req_wen;
                            wdata_q <= lsu_req_wdata;
                            wmask_q <= lsu_req_wmask;
                        end else begin
                            addr_q  <= ifu_req_addr;
                            wen_q   <= 1'b0;
                            wdata_q <= '0;
                            wmask_q <= '0;
                        end
                    end
                end

                REQ: begin
                    if (mem_req_ready) begin
                        state_q         <= WAIT;
                        mem_req_valid_q <= 1'b0;
                        cnt_q           <= cnt_d;
                    end else if (timeout_hit) begin
                        state_q          <= RESP;
                        mem_req_valid_q  <= 1'b0;
                        resp_data_q      <= '0;
                        resp_err_q       <= 1'b1;
                        ifu_resp_valid_q <= (owner_q == OWN_IFU);
                        lsu_resp_valid_q <= (owner_q == OWN_LSU);
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                WAIT: begin
                    if (mem_resp_valid) begin
                        state_q          <= RESP;
                        // Stores complete with zero data.
                        resp_data_q      <= wen_q ? '0 : mem_resp_data;
                        resp_err_q       <= 1'b0;
                        ifu_resp_valid_q <= (owner_q == OWN_IFU);
                        lsu_resp_valid_q <= (owner_q == OWN_LSU);
                    end else if (timeout_hit) begin
                        state_q          <= RESP;
                        resp_data_q      <= '0;
                        resp_err_q       <= 1'b1;
                        ifu_resp_valid_q <= (owner_q == OWN_IFU);
                        lsu_resp_valid_q <= (owner_q == OWN_LSU);
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                RESP: begin
                    if (owner_resp_ready) begin
                        state_q          <= IDLE;
                        ifu_resp_valid_q <= 1'b0;
                        lsu_resp_valid_q <= 1'b0;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_valid  = mem_req_valid_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_wen    = wen_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wmask  = wmask_q;
    assign mem_resp_ready = (state_q != RESP);

    assign ifu_resp_valid = ifu_resp_valid_q;
    assign ifu_resp_data  = resp_data_q;
    assign ifu_resp_err   = resp_err_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign lsu_resp_data  = resp_data_q;
    assign lsu_resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed, table-driven bench for mem_arbiter plus hand-written timeout/backpressure/reset sequences.
// Latency : n/a.
// Backpressure: the bench plays the memory side and both requesters.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
    logic [31:0] ifu_req_addr, ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
    logic [3:0]  lsu_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
    logic [3:0]  mem_req_wmask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data)
    );

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic [31:0] ifu_addr;
        logic [31:0] lsu_addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;      // what the memory returns
        logic        exp_lsu;    // expected winner: 1 = LSU
        logic [31:0] exp_resp;   // expected response data
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, ".ifu_req_ready"},  ifu_req_ready,  1'b0);
        chk1({tag, ".lsu_req_ready"},  lsu_req_ready,  1'b0);
        chk1({tag, ".mem_req_valid"},  mem_req_valid,  1'b0);
        chk1({tag, ".mem_resp_ready"}, mem_resp_ready, 1'b1);
        chk1({tag, ".ifu_resp_valid"}, ifu_resp_valid, 1'b0);
        chk1({tag, ".lsu_resp_valid"}, lsu_resp_valid, 1'b0);
        chk1({tag, ".resp_err"},       ifu_resp_err | lsu_resp_err, 1'b0);
        chk ({tag, ".resp_data"},      ifu_resp_data | lsu_resp_data, 32'h0);
        chk ({tag, ".mem_req_addr"},   mem_req_addr,   32'h0);
        chk1({tag, ".mem_req_wen"},    mem_req_wen,    1'b0);
        chk ({tag, ".mem_req_wmask"},  {28'h0, mem_req_wmask}, 32'h0);
    endtask

    // Starts at the first negedge in REQ; plays a zero-wait memory and consumes the response.
    task automatic finish_txn(input logic is_lsu, input logic [31:0] rdata,
                              input logic [31:0] exp_data, input string tag);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk1({tag, ".wait.mem_req_valid"}, mem_req_valid, 1'b0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = rdata;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk1({tag, ".owner_resp_valid"}, is_lsu ? lsu_resp_valid : ifu_resp_valid, 1'b1);
        chk1({tag, ".other_resp_valid"}, is_lsu ? ifu_resp_valid : lsu_resp_valid, 1'b0);
        chk ({tag, ".resp_data"},        is_lsu ? lsu_resp_data  : ifu_resp_data,  exp_data);
        chk1({tag, ".resp_err"},         is_lsu ? lsu_resp_err   : ifu_resp_err,   1'b0);
        chk1({tag, ".mem_resp_ready"},   mem_resp_ready, 1'b0);
        if (is_lsu) lsu_resp_ready = 1'b1; else ifu_resp_ready = 1'b1;
        @(negedge clk);
        lsu_resp_ready = 1'b0;
        ifu_resp_ready = 1'b0;
        chk1({tag, ".done_resp_valid"}, ifu_resp_valid | lsu_resp_valid, 1'b0);
        chk1({tag, ".idle_mem_resp_ready"}, mem_resp_ready, 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        ifu_req_valid = v.ifu_v;  ifu_req_addr  = v.ifu_addr;
        lsu_req_valid = v.lsu_v;  lsu_req_addr  = v.lsu_addr;
        lsu_req_wen   = v.wen;    lsu_req_wdata = v.wdata;   lsu_req_wmask = v.wmask;
        #1;
        chk1({tag, ".ifu_req_ready"}, ifu_req_ready, !v.exp_lsu);
        chk1({tag, ".lsu_req_ready"}, lsu_req_ready, v.exp_lsu);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        chk1({tag, ".mem_req_valid"}, mem_req_valid, 1'b1);
        chk ({tag, ".mem_req_addr"},  mem_req_addr, v.exp_lsu ? v.lsu_addr : v.ifu_addr);
        chk1({tag, ".mem_req_wen"},   mem_req_wen,  v.exp_lsu ? v.wen : 1'b0);
        chk ({tag, ".mem_req_wmask"}, {28'h0, mem_req_wmask}, {28'h0, v.exp_lsu ? v.wmask : 4'h0});
        if (v.exp_lsu) chk({tag, ".mem_req_wdata"}, mem_req_wdata, v.wdata);
        finish_txn(v.exp_lsu, v.rdata, v.exp_resp, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

    initial begin
        int   k;
        vec_t v;

        //          ifu_v lsu_v ifu_addr      lsu_addr      wen   wdata         wmask rdata         lsu  resp
        vecs[0] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,        1'b0, 32'h0,        4'h0, 32'h0000_0413, 1'b0, 32'h0000_0413};
        vecs[1] = '{1'b0, 1'b1, 32'h0,        32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 1'b1, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 32'h0,        32'h8000_0200, 1'b0, 32'h0,        4'h0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
`ifdef MEM_ARB_RR_EN
        // last grant was LSU (vector 2), so ties alternate IFU, LSU, IFU.
        vecs[3] = '{1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b0, 32'h0,   4'h0, 32'h0000_0AA1, 1'b0, 32'h0000_0AA1};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_1004, 32'h0000_2004, 1'b0, 32'h0,   4'h0, 32'h0000_0AA2, 1'b1, 32'h0000_0AA2};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_1008, 32'h0000_2008, 1'b0, 32'h0,   4'h0, 32'h0000_0AA3, 1'b0, 32'h0000_0AA3};
`else
        vecs[3] = '{1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b0, 32'h0,   4'h0, 32'h0000_0AA1, 1'b1, 32'h0000_0AA1};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_1004, 32'h0000_2004, 1'b0, 32'h0,   4'h0, 32'h0000_0AA2, 1'b1, 32'h0000_0AA2};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_1008, 32'h0000_2008, 1'b1, 32'h5555_AAAA, 4'h3, 32'h0000_0AA3, 1'b1, 32'h0};
`endif

        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_resp_ready = 1'b0;
        lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
        lsu_req_wdata = '0;   lsu_req_wmask = '0; lsu_resp_ready = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Memory never answers: with a limit of 4, RESP appears 5 edges after acceptance.
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h0000_3000;
        #1 chk1("to.ifu_req_ready", ifu_req_ready, 1'b1);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        chk1("to.mem_req_valid", mem_req_valid, 1'b1);
        k = 0;
        while (!ifu_resp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("to.cycles", k, 5);
        chk1("to.resp_valid", ifu_resp_valid, 1'b1);
        chk1("to.resp_err", ifu_resp_err, 1'b1);
        chk("to.resp_data", ifu_resp_data, 32'h0);
        chk1("to.mem_req_valid_dropped", mem_req_valid, 1'b0);
        ifu_resp_ready = 1'b1;
        @(negedge clk);
        ifu_resp_ready = 1'b0;
        // Late response arrives while idle and must be dropped.
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0BAD;
        #1 chk1("stray.mem_resp_ready", mem_resp_ready, 1'b1);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk1("stray.no_resp", ifu_resp_valid | lsu_resp_valid, 1'b0);
        v = '{1'b0, 1'b1, 32'h0, 32'h0000_4000, 1'b0, 32'h0, 4'h0, 32'h0000_600D, 1'b1, 32'h0000_600D};
        run_vec(v, "after_to");

        // LSU holds off its response for 5 cycles while IFU waits.
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_5000; lsu_req_wen = 1'b0; lsu_req_wmask = 4'h0;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_6000;
        #1 chk1("bp.lsu_req_ready", lsu_req_ready, 1'b1);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h55AA_0001;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            chk1($sformatf("bp%0d.lsu_resp_valid", i), lsu_resp_valid, 1'b1);
            chk ($sformatf("bp%0d.lsu_resp_data", i),  lsu_resp_data,  32'h55AA_0001);
            chk1($sformatf("bp%0d.mem_resp_ready", i), mem_resp_ready, 1'b0);
            chk1($sformatf("bp%0d.ifu_req_ready", i),  ifu_req_ready,  1'b0);
            @(negedge clk);
        end
        lsu_resp_ready = 1'b1;
        @(negedge clk);
        lsu_resp_ready = 1'b0;
        #1 chk1("bp.ifu_granted", ifu_req_ready, 1'b1);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        chk("bp.ifu_addr", mem_req_addr, 32'h0000_6000);
        finish_txn(1'b0, 32'h0000_0777, 32'h0000_0777, "bp.ifu");

        // Reset in WAIT abandons the transaction.
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h0000_7000;
        @(negedge clk);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midrst");
        rst = 1'b0;
        v = '{1'b1, 1'b0, 32'h0000_7004, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0000_0013, 1'b0, 32'h0000_0013};
        run_vec(v, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
